// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter for the shared fetch/data memory port
// Data wins contention unless it also won the previous grant; a response timeout aborts the access.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_valid,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_valid,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    stall_f,
  output logic                    stall_m,
  output logic                    timeout_err
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;   // 1 = data, 0 = fetch
  logic                  last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  terr_q, terr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BW-1:0]         be_q, be_d;
  logic                  done, tmo, pick_dm;
  logic [CW-1:0]         cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    done    = 1'b0;
    tmo     = 1'b0;
    pick_dm = dm_req & ~(if_req & last_q);
    cnt_inc = (cnt_q == TMAX) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (if_req | dm_req) begin
          state_d = S_ISSUE;
          owner_d = pick_dm;
          cnt_d   = '0;
          if (pick_dm) begin
            we_d    = dm_we;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
            be_d    = dm_be;
          end else begin
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
            be_d    = '1;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_inc;
        if (cnt_q == TMAX) tmo = 1'b1;
        else if (mem_gnt) state_d = S_RESP;
      end
      S_RESP: begin
        cnt_d = cnt_inc;
        if (mem_rvalid) done = 1'b1;
        else if (cnt_q == TMAX) tmo = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // A timeout completes the access too, so it counts toward the alternation.
    if (done | tmo) begin
      state_d = S_IDLE;
      last_d  = owner_q;
    end
    if (tmo) terr_d = 1'b1;
  end

  assign if_valid    = (done | tmo) & ~owner_q;
  assign dm_valid    = (done | tmo) & owner_q;
  assign if_rdata    = (done & ~owner_q) ? mem_rdata : '0;
  assign dm_rdata    = (done & owner_q) ? mem_rdata : '0;
  assign mem_req     = (state_q == S_ISSUE);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign stall_f     = if_req & ~if_valid;
  assign stall_m     = dm_req & ~dm_valid;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        dm_valid;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_f, stall_m, timeout_err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic        exp_dm;
    logic [31:0] rd;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_be = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0;
    tick(); tick();
    settle();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_valids", {if_valid, dm_valid}, 2'b00);

    // lone load
    rst_n = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    settle();
    chk("ld_c0_mem_req", mem_req, 1'b0);
    chk("ld_c0_stall_m", stall_m, 1'b1);
    tick(); mem_gnt = 1'b1; settle();
    chk("ld_c1_mem_req", mem_req, 1'b1);
    chk("ld_c1_addr", mem_addr, 32'h100);
    chk("ld_c1_stall_m", stall_m, 1'b1);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; settle();
    chk("ld_c2_mem_req", mem_req, 1'b0);
    chk("ld_c2_dm_valid", dm_valid, 1'b1);
    chk("ld_c2_dm_rdata", dm_rdata, 32'hDEADBEEF);
    chk("ld_c2_if_valid", if_valid, 1'b0);
    chk("ld_c2_stall_m", stall_m, 1'b0);
    tick(); dm_req = 1'b0; mem_rvalid = 1'b0; settle();
    chk("ld_c3_dm_valid", dm_valid, 1'b0);
    chk("ld_c3_dm_rdata", dm_rdata, 32'h0);

    // contention from reset: data, fetch, data, fetch
    rst_n = 1'b0; tick();
    rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_addr = 32'h300;
    dm_we = 1'b0; dm_wdata = 32'h55; dm_be = 4'h1;
    for (int g = 0; g < 4; g++) begin
      exp_dm = (g % 2 == 0);
      rd = 32'hA000 + g;
      settle();
      chk("ct_idle_mem_req", mem_req, 1'b0);
      tick(); mem_gnt = 1'b1; settle();
      chk("ct_issue_addr", mem_addr, exp_dm ? 32'h300 : 32'h200);
      chk("ct_issue_be", mem_be, exp_dm ? 4'h1 : 4'hF);
      chk("ct_issue_wdata", mem_wdata, exp_dm ? 32'h55 : 32'h0);
      tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd; settle();
      chk("ct_valids", {if_valid, dm_valid}, exp_dm ? 2'b01 : 2'b10);
      chk("ct_rdata", exp_dm ? dm_rdata : if_rdata, rd);
      tick(); mem_rvalid = 1'b0;
      if (g == 3) begin if_req = 1'b0; dm_req = 1'b0; end
    end

    // store with grant withheld 3 cycles
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_wdata = 32'h1234; dm_addr = 32'h400;
    tick();
    for (int k = 0; k < 4; k++) begin
      mem_gnt = (k == 3);
      if (k == 1) dm_wdata = 32'hFFFF;
      settle();
      chk("st_mem_req", mem_req, 1'b1);
      chk("st_fields", {mem_we, mem_be, mem_wdata}, {1'b1, 4'b0011, 32'h1234});
      chk("st_no_valid", dm_valid, 1'b0);
      tick();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0; settle();
    chk("st_dm_valid", dm_valid, 1'b1);
    chk("st_stall_m", stall_m, 1'b0);
    tick(); mem_rvalid = 1'b0; dm_req = 1'b0; dm_we = 1'b0; settle();

    // stray response in IDLE, then in ISSUE
    mem_rvalid = 1'b1; mem_rdata = 32'h77; settle();
    chk("sx_idle_valids", {if_valid, dm_valid}, 2'b00);
    tick(); mem_rvalid = 1'b0; settle();
    chk("sx_idle_mem_req", mem_req, 1'b0);
    if_req = 1'b1; if_addr = 32'h500;
    tick(); mem_rvalid = 1'b1; settle();
    chk("sx_issue_valids", {if_valid, dm_valid}, 2'b00);
    chk("sx_issue_mem_req", mem_req, 1'b1);
    tick(); mem_rvalid = 1'b0; mem_gnt = 1'b1; settle();
    chk("sx_still_issue", mem_req, 1'b1);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A; settle();
    chk("sx_if_valid", if_valid, 1'b1);
    chk("sx_if_rdata", if_rdata, 32'h5A5A);
    tick(); mem_rvalid = 1'b0; if_req = 1'b0;

    // timeout on a fetch
    if_req = 1'b1; if_addr = 32'h600; mem_rdata = 32'hBAD;
    tick(); mem_gnt = 1'b1; settle();
    chk("to_issue", mem_req, 1'b1);
    tick(); mem_gnt = 1'b0;
    for (int k = 1; k < 15; k++) begin
      settle();
      chk("to_wait_valid", if_valid, 1'b0);
      chk("to_wait_stall", stall_f, 1'b1);
      tick();
    end
    settle();
    chk("to_if_valid", if_valid, 1'b1);
    chk("to_if_rdata", if_rdata, 32'h0);
    chk("to_stall_f", stall_f, 1'b0);
    tick(); if_req = 1'b0; mem_rvalid = 1'b1; settle();
    chk("to_terr", timeout_err, 1'b1);
    chk("to_late_valid", {if_valid, dm_valid}, 2'b00);
    tick(); mem_rvalid = 1'b0; settle();
    chk("to_terr_sticky", timeout_err, 1'b1);
    chk("to_idle", mem_req, 1'b0);

    // reset during RESP
    if_req = 1'b1; if_addr = 32'h700;
    tick(); mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; rst_n = 1'b0; if_req = 1'b0;
    tick(); rst_n = 1'b1; mem_rvalid = 1'b1; settle();
    chk("rm_valids", {if_valid, dm_valid}, 2'b00);
    chk("rm_mem_req", mem_req, 1'b0);
    chk("rm_mem_addr", mem_addr, 32'h0);
    chk("rm_terr", timeout_err, 1'b0);
    tick(); mem_rvalid = 1'b0; dm_req = 1'b1; dm_addr = 32'h800; settle();
    chk("rm_new_idle", mem_req, 1'b0);
    tick(); mem_gnt = 1'b1; settle();
    chk("rm_new_issue", mem_addr, 32'h800);
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hC0DE; settle();
    chk("rm_new_valid", dm_valid, 1'b1);
    chk("rm_new_rdata", dm_rdata, 32'hC0DE);
    tick(); mem_rvalid = 1'b0; dm_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
